// File: rtl/risc_mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the core/datapath/memory side (slave).
interface risc_mc_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic [3:0]       opcode;
    logic             alu_zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel_d;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             rf_we;
    logic             wb_sel;
    logic [2:0]       alu_op;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, alu_zero, mem_ack,
        output mem_req, mem_we, mem_sel_d, ir_we, pc_we, pc_src,
               rf_we, wb_sel, alu_op, busy, err, retired
    );

    modport slave (
        output run, opcode, alu_zero, mem_ack,
        input  mem_req, mem_we, mem_sel_d, ir_we, pc_we, pc_src,
               rf_we, wb_sel, alu_op, busy, err, retired
    );
endinterface

// File: rtl/risc_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC datapath.
// Every output is a flop decoded from the next state, so it is valid in the cycle that state is entered.
// Consequently the branch decision uses alu_zero as presented on the edge that enters EXEC.
module risc_mc_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    risc_mc_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SLT = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    // Last value the wait counter may hold before a further unacknowledged cycle is a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            4'h3, OP_BEQ, OP_BNE: return 3'd1;  // SUB, and compare for branches
            4'h4:                 return 3'd2;  // INV
            4'h5:                 return 3'd3;  // LSL
            4'h6:                 return 3'd4;  // LSR
            4'h7:                 return 3'd5;  // AND
            4'h8:                 return 3'd6;  // OR
            OP_SLT:               return 3'd7;
            default:              return 3'd0;  // ADD, LD/ST address add, JMP, illegal
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             taken;

    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_sel_data_q, mem_sel_data_d;
    logic       ir_we_q, ir_we_d;
    logic       pc_we_q, pc_we_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic       rf_we_q, rf_we_d;
    logic       wb_sel_q, wb_sel_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    // Next state, opcode latch, memory wait counter and retire counting.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        opcode_d  = opcode_q;
        wait_d    = '0;
        retired_d = retired_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ack)               state_d = S_DECODE;
                else if (wait_q == WAIT_LAST)  state_d = S_ERROR;
                else                           wait_d  = wait_q + 8'd1;
            end
            S_DECODE: begin
                opcode_d = bus.opcode;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu(opcode_q))                              state_d = S_WB;
                else if ((opcode_q == OP_LD) || (opcode_q == OP_ST)) state_d = S_MEM;
                else                                               retire  = 1'b1;
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    if (opcode_q == OP_ST) retire  = 1'b1;
                    else                   state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:    retire  = 1'b1;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
        // Instruction boundary: count it and either continue or park in IDLE.
        if (retire) begin
            state_d   = bus.run ? S_FETCH : S_IDLE;
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Registered outputs decoded from the state being entered (opcode_d is the live opcode when entering EXEC).
    always_comb begin
        taken = (state_d == S_EXEC) &&
                (((opcode_d == OP_BEQ) &&  bus.alu_zero) ||
                 ((opcode_d == OP_BNE) && !bus.alu_zero) ||
                  (opcode_d == OP_JMP));
        mem_req_d      = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_sel_data_d = (state_d == S_MEM);
        mem_we_d       = (state_d == S_MEM) && (opcode_d == OP_ST);
        ir_we_d        = (state_q == S_FETCH) && (state_d == S_DECODE);
        pc_we_d        = ir_we_d || taken;
        pc_src_d       = taken ? ((opcode_d == OP_JMP) ? 2'd2 : 2'd1) : 2'd0;
        rf_we_d        = (state_d == S_WB);
        wb_sel_d       = (state_d == S_WB) && (opcode_d == OP_LD);
        // ALU select is held from EXEC through WB so the result stays stable for write-back.
        alu_op_d       = ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB))
                         ? alu_op_of(opcode_d) : 3'd0;
        busy_d         = (state_d != S_IDLE) && (state_d != S_ERROR);
        err_d          = err_q || (state_d == S_ERROR);
    end

    // State, counters and output flops; asynchronous reset returns everything to zero/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            opcode_q       <= '0;
            wait_q         <= '0;
            retired_q      <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_sel_data_q <= 1'b0;
            ir_we_q        <= 1'b0;
            pc_we_q        <= 1'b0;
            pc_src_q       <= '0;
            rf_we_q        <= 1'b0;
            wb_sel_q       <= 1'b0;
            alu_op_q       <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            wait_q         <= wait_d;
            retired_q      <= retired_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_sel_data_q <= mem_sel_data_d;
            ir_we_q        <= ir_we_d;
            pc_we_q        <= pc_we_d;
            pc_src_q       <= pc_src_d;
            rf_we_q        <= rf_we_d;
            wb_sel_q       <= wb_sel_d;
            alu_op_q       <= alu_op_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel_d = mem_sel_data_q;
    assign bus.ir_we     = ir_we_q;
    assign bus.pc_we     = pc_we_q;
    assign bus.pc_src    = pc_src_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.wb_sel    = wb_sel_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.retired   = retired_q;

endmodule
